imem_fetch_ctrl: RTL and testbench

//  Instruction-fetch controller between the CPU (PC/INSTRUCTION) and a byte-wide, variable-latency

---
 rtl/imem_fetch_ctrl_pkg.sv | 21 ++
 rtl/imem_fetch_ctrl_if.sv | 30 +++
 rtl/imem_byte_assembler.sv | 41 ++++
 rtl/imem_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM states, memory geometry,
// default timeout and the word returned on a failed fetch.
package imem_fetch_ctrl_pkg;

  localparam int          IMEM_ADDR_W     = 10;
  localparam int          BYTES_PER_WORD  = 4;
  localparam int          LANE_W          = $clog2(BYTES_PER_WORD);
  localparam int          TIMEOUT_CYC_DEF = 16;
  localparam logic [31:0] NOP_INSTR_DEF   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  function automatic logic word_aligned(input logic [LANE_W-1:0] byte_offset);
    return byte_offset == '0;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// CPU fetch port and byte-wide instruction-memory port of the fetch controller.
// slave: the controller's view; master: the CPU + memory side driving it.
interface imem_fetch_ctrl_if
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) ();

  logic [31:0]       PC;
  logic              FETCH_REQ;
  logic [31:0]       INSTRUCTION;
  logic              INSTR_VALID;
  logic              BUSYWAIT;
  logic              FETCH_ERR;
  logic              MEM_READ;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_RDATA;
  logic              MEM_READY;

  modport slave (
    input  PC, FETCH_REQ, MEM_RDATA, MEM_READY,
    output INSTRUCTION, INSTR_VALID, BUSYWAIT, FETCH_ERR, MEM_READ, MEM_ADDR
  );

  modport master (
    output PC, FETCH_REQ, MEM_RDATA, MEM_READY,
    input  INSTRUCTION, INSTR_VALID, BUSYWAIT, FETCH_ERR, MEM_READ, MEM_ADDR
  );

endinterface

// File: rtl/imem_byte_assembler.sv
// Collects the bytes of one fetch into little-endian lanes (lane 0 -> bits [7:0]).
// word_next_o already contains the byte being accepted this cycle.
module imem_byte_assembler
  import imem_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic [LANE_W-1:0] cnt_o,
  output logic              last_byte_o,
  output logic [31:0]       word_next_o
);

  logic [LANE_W-1:0]                cnt_q;
  logic [BYTES_PER_WORD-1:0][7:0]   lanes_q;
  logic [BYTES_PER_WORD-1:0][7:0]   lanes_d;

  assign cnt_o       = cnt_q;
  assign last_byte_o = (cnt_q == LANE_W'(BYTES_PER_WORD - 1));
  assign word_next_o = lanes_d;

  // NOTE: default assignment first so every path drives lanes_d and no latch is inferred.
  always_comb begin
    lanes_d = lanes_q;
    if (byte_valid_i) lanes_d[cnt_q] = byte_i;
  end

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q   <= '0;
      lanes_q <= '0;
    end else if (byte_valid_i) begin
      lanes_q <= lanes_d;
      cnt_q   <= last_byte_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: reads 4 bytes per fetch, stalls the CPU meanwhile, and returns
// NOP_INSTR with FETCH_ERR on misaligned/out-of-range/timed-out fetches. Optional hit buffer: FETCH_HIT_BUF_EN.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = IMEM_ADDR_W,
  parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEF
) (
  input logic              CLK,
  input logic              RESET,
  imem_fetch_ctrl_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] base_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              mem_read_q;
  logic              instr_valid_q;
  logic              fetch_err_q;
  logic [31:0]       instr_q;

  logic              accept;
  logic              pc_err;
  logic              byte_take;
  logic              tmo_abort;
  logic              fill;
  logic              hit;
  logic [31:0]       buf_word;
  logic [LANE_W-1:0] asm_cnt;
  logic              asm_last;
  logic [31:0]       asm_word;

  assign accept    = (state_q == ST_IDLE) && bus.FETCH_REQ;
  assign pc_err    = !word_aligned(bus.PC[LANE_W-1:0]) || (bus.PC[31:ADDR_W] != '0);
  // A byte arriving on the last allowed cycle still wins over the timeout.
  assign byte_take = (state_q == ST_READ) && bus.MEM_READY;
  assign tmo_abort = (state_q == ST_READ) && !bus.MEM_READY && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign fill      = byte_take && asm_last;

  imem_byte_assembler u_asm (
    .clk          (CLK),
    .rst          (RESET),
    .clear_i      (accept),
    .byte_valid_i (byte_take),
    .byte_i       (bus.MEM_RDATA),
    .cnt_o        (asm_cnt),
    .last_byte_o  (asm_last),
    .word_next_o  (asm_word)
  );

`ifdef FETCH_HIT_BUF_EN
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_base_q;
  logic [31:0]       buf_word_q;

  assign hit      = buf_valid_q && (buf_base_q == bus.PC[ADDR_W-1:0]);
  assign buf_word = buf_word_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      buf_valid_q <= 1'b0;
    end else if ((accept && pc_err) || tmo_abort) begin
      buf_valid_q <= 1'b0;
    end else if (fill) begin
      buf_valid_q <= 1'b1;
    end
  end

  // NOTE: payload registers carry no reset; buf_valid_q alone decides whether they are used.
  always_ff @(posedge CLK) begin
    if (fill) begin
      buf_base_q <= base_q;
      buf_word_q <= asm_word;
    end
  end
`else
  assign hit      = 1'b0;
  assign buf_word = NOP_INSTR;
`endif

  assign bus.MEM_ADDR    = base_q + ADDR_W'(asm_cnt);
  assign bus.MEM_READ    = mem_read_q;
  assign bus.INSTRUCTION = instr_q;
  assign bus.INSTR_VALID = instr_valid_q;
  assign bus.FETCH_ERR   = fetch_err_q;
  assign bus.BUSYWAIT    = (state_q == ST_READ) || accept;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      tmo_q         <= '0;
      mem_read_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      instr_q       <= '0;
    end else begin
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            base_q <= bus.PC[ADDR_W-1:0];
            tmo_q  <= '0;
            if (pc_err) begin
              state_q       <= ST_DONE;
              instr_valid_q <= 1'b1;
              fetch_err_q   <= 1'b1;
              instr_q       <= NOP_INSTR;
            end else if (hit) begin
              state_q       <= ST_DONE;
              instr_valid_q <= 1'b1;
              instr_q       <= buf_word;
            end else begin
              state_q    <= ST_READ;
              mem_read_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (byte_take) begin
            tmo_q <= '0;
            if (asm_last) begin
              state_q       <= ST_DONE;
              mem_read_q    <= 1'b0;
              instr_valid_q <= 1'b1;
              instr_q       <= asm_word;
            end
          end else if (tmo_abort) begin
            state_q       <= ST_DONE;
            mem_read_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            fetch_err_q   <= 1'b1;
            instr_q       <= NOP_INSTR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: expected words are queued at request time and
// compared when INSTR_VALID pulses; latency and memory-side behaviour are checked per fetch.
module tb_imem_fetch_ctrl;
  import imem_fetch_ctrl_pkg::*;

  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(.ADDR_W(IMEM_ADDR_W)) bus ();

  imem_fetch_ctrl dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  logic [7:0] mem [0:1023];
  assign bus.MEM_RDATA = mem[bus.MEM_ADDR];

  int         n_checks = 0;
  int         n_fail   = 0;
  int         rdy_mode = 0;
  int         wcnt     = 0;
  exp_t       exp_q[$];
  logic [9:0] addr_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [9:0] b);
    return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
  endfunction

  // Memory responder. Modes: 0 always ready, 1 ready every 3rd cycle,
  // 2 never ready on byte lane 2, 3 ready on lane 2 only after 15 waits.
  always @(negedge clk) begin
    logic r;
    if (bus.MEM_READ !== 1'b1) begin
      bus.MEM_READY = 1'b0;
      wcnt = 0;
    end else begin
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (wcnt == 2);
        2:       r = (bus.MEM_ADDR[1:0] != 2'd2);
        default: r = (bus.MEM_ADDR[1:0] != 2'd2) || (wcnt == 15);
      endcase
      bus.MEM_READY = r;
      if (r) begin
        wcnt = 0;
        addr_log.push_back(bus.MEM_ADDR);
      end else begin
        wcnt++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.INSTR_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_word", bus.INSTRUCTION, e.word);
        check("sb_err", {31'd0, bus.FETCH_ERR}, {31'd0, e.err});
      end
    end
  end

  task automatic do_fetch(input string tag, input logic [31:0] pc, input int exp_lat,
                          input logic exp_err, input logic [31:0] exp_word, input logic exp_mrd);
    int   lat;
    logic saw_rd;
    logic busy_bad;
    exp_t e;
    @(negedge clk);
    bus.PC        = pc;
    bus.FETCH_REQ = 1'b1;
    e.err  = exp_err;
    e.word = exp_word;
    exp_q.push_back(e);
    addr_log.delete();
    #1 check({tag, "_busy_accept"}, {31'd0, bus.BUSYWAIT}, 32'd1);
    @(negedge clk);
    bus.FETCH_REQ = 1'b0;
    bus.PC        = 32'hFFFF_FFFF;
    lat      = 1;
    saw_rd   = 1'b0;
    busy_bad = 1'b0;
    while (bus.INSTR_VALID !== 1'b1 && lat < 100) begin
      if (bus.MEM_READ === 1'b1) begin
        saw_rd = 1'b1;
        if (bus.BUSYWAIT !== 1'b1) busy_bad = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_mem_read_seen"}, {31'd0, saw_rd}, {31'd0, exp_mrd});
      check({tag, "_busy_in_read"}, {31'd0, busy_bad}, 32'd0);
      check({tag, "_busy_done"}, {31'd0, bus.BUSYWAIT}, 32'd0);
      check({tag, "_mem_read_done"}, {31'd0, bus.MEM_READ}, 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h0A; mem[1] = 8'h00; mem[2] = 8'h04; mem[3] = 8'h00;
    bus.PC        = 32'd0;
    bus.FETCH_REQ = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_instr", bus.INSTRUCTION, 32'd0);
    check("rst_valid", {31'd0, bus.INSTR_VALID}, 32'd0);
    check("rst_busy", {31'd0, bus.BUSYWAIT}, 32'd0);
    check("rst_err", {31'd0, bus.FETCH_ERR}, 32'd0);
    check("rst_mread", {31'd0, bus.MEM_READ}, 32'd0);
    check("rst_maddr", {22'd0, bus.MEM_ADDR}, 32'd0);
    rst = 1'b0;

    // Basic fetch, ready every cycle
    rdy_mode = 0;
    do_fetch("t1", 32'd0, 5, 1'b0, 32'h0004_000A, 1'b1);

    // Slow memory: address must step 8..11, each accepted once
    rdy_mode = 1;
    do_fetch("t2", 32'd8, 13, 1'b0, model_word(10'd8), 1'b1);
    check("t2_nbytes", addr_log.size(), 4);
    for (int i = 0; i < addr_log.size(); i++) check("t2_addr", {22'd0, addr_log[i]}, 8 + i);

    // Misaligned and out of range
    rdy_mode = 0;
    do_fetch("t3a", 32'd6, 1, 1'b1, NOP_INSTR_DEF, 1'b0);
    do_fetch("t3b", 32'h400, 1, 1'b1, NOP_INSTR_DEF, 1'b0);

    // Timeout on byte 2, then recovery
    rdy_mode = 2;
    do_fetch("t4", 32'd16, 19, 1'b1, NOP_INSTR_DEF, 1'b1);
    rdy_mode = 0;
    do_fetch("t4b", 32'd0, 5, 1'b0, 32'h0004_000A, 1'b1);

    // Ready coincides with timeout expiry, at the top of memory
    rdy_mode = 3;
    do_fetch("t4c", 32'h3FC, 20, 1'b0, model_word(10'h3FC), 1'b1);
    check("t4c_nbytes", addr_log.size(), 4);
    for (int i = 0; i < addr_log.size(); i++) check("t4c_addr", {22'd0, addr_log[i]}, 32'h3FC + i);

    // Reset in READ with two bytes collected and ready high
    rdy_mode = 0;
    @(negedge clk);
    bus.PC        = 32'h40;
    bus.FETCH_REQ = 1'b1;
    @(negedge clk);
    bus.FETCH_REQ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_addr_cnt2", {22'd0, bus.MEM_ADDR}, 32'h42);
    rst = 1'b1;
    @(negedge clk);
    check("t5_instr", bus.INSTRUCTION, 32'd0);
    check("t5_valid", {31'd0, bus.INSTR_VALID}, 32'd0);
    check("t5_busy", {31'd0, bus.BUSYWAIT}, 32'd0);
    check("t5_err", {31'd0, bus.FETCH_ERR}, 32'd0);
    check("t5_mread", {31'd0, bus.MEM_READ}, 32'd0);
    check("t5_maddr", {22'd0, bus.MEM_ADDR}, 32'd0);
    rst = 1'b0;
    do_fetch("t5b", 32'h40, 5, 1'b0, model_word(10'h40), 1'b1);

    // Refetch of the same word
    do_fetch("t6a", 32'd4, 5, 1'b0, model_word(10'd4), 1'b1);
`ifdef FETCH_HIT_BUF_EN
    do_fetch("t6b", 32'd4, 1, 1'b0, model_word(10'd4), 1'b0);
`else
    do_fetch("t6b", 32'd4, 5, 1'b0, model_word(10'd4), 1'b1);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
